// File: rtl/riscv_pkg.sv
// Shared core-wide constants and inter-stage bundle types.
// Imported by every pipeline stage.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer between fetch and decode.
// Flush has priority over push and pop.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;

   assign rdata = mem[head];
   assign full  = (count == CW'(DEPTH));

   // Storage is not reset; count gates every read.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[tail] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem addressing and the
// fetch buffer feeding decode over valid/ready.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   pc_q;
   logic          push;
   logic          pop;
   logic          full;
   logic [CW-1:0] count;
   fetch_entry_t  wentry;
   fetch_entry_t  hentry;

   assign imem_addr = pc_q;
   assign wentry    = '{pc: pc_q, instr: imem_data};

   assign id_valid = (count != '0);
   assign pop      = id_valid & id_ready;
   // A pop frees a slot this cycle, so a full buffer still accepts.
   assign push     = !redirect_valid & (!full | pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else if (redirect_valid) begin
         pc_q <= {redirect_pc[31:2], 2'b00};
      end else if (push) begin
         pc_q <= pc_q + 32'd4;
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (wentry),
      .rdata (hentry),
      .count (count),
      .full  (full)
   );

   assign id_instr    = id_valid ? hentry.instr : NOP_INSTR;
   assign id_pc       = id_valid ? hentry.pc : 32'd0;
   assign id_pc_plus4 = id_valid ? hentry.pc + 32'd4 : 32'd0;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a small
// combinational instruction memory model.
module tb_fetch_stage;
   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;

   int total;
   int bad;

   logic [31:0] mem [64];

   localparam logic [31:0] NOP = 32'h0000_0013;

   assign imem_data = mem[imem_addr[7:2]];

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_n = 1'b0;
      id_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      @(negedge clk);
      total++;
      if (id_valid !== 1'b0 || id_instr !== NOP) begin
         bad++;
         $display("FAIL reset_out valid=%b instr=%h need 0/%h",
                  id_valid, id_instr, NOP);
      end
      total++;
      if (id_pc !== 32'd0 || id_pc_plus4 !== 32'd0) begin
         bad++;
         $display("FAIL reset_pc pc=%h p4=%h need 0/0",
                  id_pc, id_pc_plus4);
      end
      total++;
      if (imem_addr !== 32'd0) begin
         bad++;
         $display("FAIL reset_addr got %h need 0", imem_addr);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_stream;
      logic [31:0] exp_i;
      id_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cyc();
         exp_i = mem[k];
         total++;
         if (id_valid !== 1'b1 || id_pc !== 32'(4 * k)
             || id_instr !== exp_i
             || id_pc_plus4 !== 32'(4 * k + 4)) begin
            bad++;
            $display("FAIL stream%0d v=%b pc=%h i=%h p4=%h need pc=%h i=%h",
                     k, id_valid, id_pc, id_instr, id_pc_plus4,
                     32'(4 * k), exp_i);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_a;
      id_ready = 1'b0;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         cyc();
         exp_a = (k < 2) ? 32'(4 * k) : 32'd8;
         total++;
         if (id_valid !== 1'b1 || id_pc !== 32'd0
             || id_instr !== 32'h0000_0093
             || imem_addr !== exp_a) begin
            bad++;
            $display("FAIL stall%0d v=%b pc=%h i=%h addr=%h need pc=0 addr=%h",
                     k, id_valid, id_pc, id_instr, imem_addr, exp_a);
         end
      end
      id_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         total++;
         if (id_valid !== 1'b1 || id_pc !== 32'(4 * k)) begin
            bad++;
            $display("FAIL drain%0d v=%b pc=%h need pc=%h",
                     k, id_valid, id_pc, 32'(4 * k));
         end
      end
   endtask

   task automatic test_redirect;
      logic [31:0] exp_i;
      id_ready = 1'b0;
      do_reset();
      cyc();
      cyc();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0040;
      cyc();
      redirect_valid = 1'b0;
      total++;
      if (id_valid !== 1'b0 || id_instr !== NOP
          || imem_addr !== 32'h40) begin
         bad++;
         $display("FAIL redir_gap v=%b i=%h addr=%h need 0/%h/40",
                  id_valid, id_instr, imem_addr, NOP);
      end
      cyc();
      exp_i = mem[16];
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== exp_i) begin
         bad++;
         $display("FAIL redir_tgt v=%b pc=%h i=%h need pc=40 i=%h",
                  id_valid, id_pc, id_instr, exp_i);
      end
      id_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0043;
      cyc();
      redirect_valid = 1'b0;
      cyc();
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'h40) begin
         bad++;
         $display("FAIL redir_align v=%b pc=%h need pc=40",
                  id_valid, id_pc);
      end
   endtask

   task automatic test_redirect_pop;
      id_ready = 1'b0;
      do_reset();
      cyc();
      cyc();
      id_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0020;
      cyc();
      redirect_valid = 1'b0;
      total++;
      if (id_valid !== 1'b0) begin
         bad++;
         $display("FAIL rpop_empty v=%b pc=%h need v=0", id_valid, id_pc);
      end
      cyc();
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'h20) begin
         bad++;
         $display("FAIL rpop_tgt v=%b pc=%h need pc=20", id_valid, id_pc);
      end
      cyc();
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'h24) begin
         bad++;
         $display("FAIL rpop_next v=%b pc=%h need pc=24", id_valid, id_pc);
      end
   endtask

   task automatic test_wrap;
      logic [31:0] exp_i;
      id_ready = 1'b1;
      do_reset();
      cyc();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      cyc();
      redirect_valid = 1'b0;
      cyc();
      exp_i = mem[63];
      total++;
      if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'd0
          || id_instr !== exp_i) begin
         bad++;
         $display("FAIL wrap_top pc=%h p4=%h i=%h need fffffffc/0/%h",
                  id_pc, id_pc_plus4, id_instr, exp_i);
      end
      cyc();
      total++;
      if (id_pc !== 32'd0 || id_pc_plus4 !== 32'd4
          || id_instr !== 32'h0000_0093) begin
         bad++;
         $display("FAIL wrap_zero pc=%h p4=%h i=%h need 0/4/00000093",
                  id_pc, id_pc_plus4, id_instr);
      end
   endtask

   task automatic test_async_reset;
      id_ready = 1'b0;
      do_reset();
      cyc();
      cyc();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (id_valid !== 1'b0 || id_instr !== NOP
          || id_pc !== 32'd0 || imem_addr !== 32'd0) begin
         bad++;
         $display("FAIL async_rst v=%b i=%h pc=%h addr=%h need 0/%h/0/0",
                  id_valid, id_instr, id_pc, imem_addr, NOP);
      end
      @(negedge clk);
      id_ready = 1'b1;
      rst_n = 1'b1;
      cyc();
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'd0
          || id_instr !== 32'h0000_0093) begin
         bad++;
         $display("FAIL restart v=%b pc=%h i=%h need 1/0/00000093",
                  id_valid, id_pc, id_instr);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      id_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'hA000_0000 + 32'(i * 16 + 3);
      end
      mem[0] = 32'h0000_0093;
      mem[1] = 32'h0010_0113;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_pop();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
